isa_cycle_arbiter: RTL
======================

ISA_CYCLE_ARBITER -- requirements
Module: isa_cycle_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0/req1  in  1  per-requester cycle request, level, held until ack.
REQ-004 SHALL have ports: wr0/wr1  in  1  1=write, 0=read; valid while reqN high.
REQ-005 SHALL have ports: addr0/addr1  in  16  ISA I/O address; valid while reqN high.
REQ-006 SHALL have ports: wdata0/wdata1  in  8  write data; valid while reqN high.
REQ-007 SHALL have ports: ack0/ack1  out  1  one-cycle completion pulse.
REQ-008 SHALL have port: rdata  out  8  read data, valid during ack pulse.
REQ-009 SHALL have ports: eng_rd_req / eng_wr_req  out  1  drive bus engine control_in[0] / control_in[1].
REQ-010 SHALL have ports: eng_addr  out  16, eng_wdata  out  8  latched cycle address/data to the engine datapath.
REQ-011 SHALL have port: eng_data_read_n  in  1  engine read-capture strobe, active-low.
REQ-012 SHALL have port: eng_done_n  in  1  engine control_reset, active-low, one cycle per bus cycle.
REQ-013 SHALL have port: eng_rdata  in  8  data from ISA data buffer.
REQ-014 SHALL have port: busy  out  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement states IDLE, WAIT, ACK; all outputs registered or decoded from registered state only.
REQ-016 IDLE: on edge with req0|req1 high, SHALL select owner, latch wrN/addrN/wdataN into eng_* registers, set eng_wr_req=wrN, eng_rd_req=!wrN, go WAIT.
REQ-017 Selection SHALL be round-robin: single request wins; both high -> pointer owner wins; pointer toggles to non-owner on entering ACK.
REQ-018 WAIT: on edge sampling eng_data_read_n=0 SHALL capture eng_rdata into rdata register.
REQ-019 WAIT: on edge sampling eng_done_n=0 SHALL clear eng_rd_req and eng_wr_req on that same edge and go ACK (engine then sees no request in its IDLE).
REQ-020 ACK: SHALL assert ackN of owner only, for exactly one cycle, then go IDLE; reqN is not sampled in ACK.
REQ-021 Write cycle rdata SHALL hold the previous value.
REQ-022 Requester dropping reqN during WAIT SHALL NOT abort the cycle; ack still pulses.
REQ-023 eng_rd_req and eng_wr_req SHALL never be high simultaneously.
REQ-024 With an 8-cycle engine sequence, ackN SHALL rise 8 edges after the edge that sampled reqN in IDLE.
REQ-025 Back-to-back: requester re-asserting after ack SHALL be granted no earlier than the edge following ACK.

Reset
REQ-026 reset low SHALL immediately force state=IDLE, eng_rd_req=0, eng_wr_req=0, eng_addr=0, eng_wdata=0, rdata=0, ack0=ack1=0, busy=0, pointer=requester 0.
REQ-027 Reset mid-cycle SHALL abandon the cycle with no ack; first request after release is handled normally.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN SHALL compile in a watchdog: 6-bit counter cleared on entering WAIT, incremented each WAIT cycle; at 63 without eng_done_n low, clear eng requests, load rdata=8'hFF, go ACK, pulse output timeout_err (out 1, reset 0) together with ack.
REQ-029 Without ARB_TIMEOUT_EN, SHALL have no counter and no timeout_err port; WAIT persists until eng_done_n low.

Verification
REQ-030 req0=1,wr0=1,addr0=16'h0220,wdata0=8'h5A, engine model -> eng_wr_req high cycles 1-7, eng_addr=0220, eng_wdata=5A, ack0 pulse at edge 8, ack1 never.
REQ-031 req1=1,wr1=0,addr1=16'h0388, eng_rdata=8'hC3 at strobe -> eng_rd_req only, rdata=C3 during ack1.
REQ-032 req0 and req1 both held high from reset -> grants 0,1,0,1; no overlapping eng requests; each ack one cycle.
REQ-033 reset pulsed low mid-WAIT -> all outputs at reset values asynchronously, no ack; next req0 completes normally.
REQ-034 ARB_TIMEOUT_EN, engine never asserts eng_done_n, read req0 -> after 63 WAIT cycles ack0 and timeout_err pulse together, rdata=FF, eng_rd_req low.

Source files
------------

// File: rtl/isa_cycle_arbiter_if.sv
// Requester-side bus of the ISA cycle arbiter.
// Two requesters share one read-data return path.
interface isa_cycle_arbiter_if;
    logic        req0;
    logic        req1;
    logic        wr0;
    logic        wr1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic        ack0;
    logic        ack1;
    logic [7:0]  rdata;

    modport master (
        output req0, req1, wr0, wr1,
        output addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, wr0, wr1,
        input  addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata
    );
endinterface

// File: rtl/isa_cycle_arbiter.sv
// Round-robin arbiter feeding one ISA bus engine from two requesters.
// Define ARB_TIMEOUT_EN to add the WAIT watchdog and timeout_err output.
module isa_cycle_arbiter (
    input  logic                clk,
    input  logic                reset,
    isa_cycle_arbiter_if.slave  bus,
    output logic                eng_rd_req,
    output logic                eng_wr_req,
    output logic [15:0]         eng_addr,
    output logic [7:0]          eng_wdata,
    input  logic                eng_data_read_n,
    input  logic                eng_done_n,
    input  logic [7:0]          eng_rdata,
`ifdef ARB_TIMEOUT_EN
    output logic                timeout_err,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        ptr, ptr_nxt;
    logic        rd_nxt, wr_nxt;
    logic [15:0] addr_nxt;
    logic [7:0]  wdata_nxt;
    logic [7:0]  rdata_q, rdata_nxt;
    logic        sel_wr;

`ifdef ARB_TIMEOUT_EN
    logic [5:0]  wd_cnt, wd_cnt_nxt;
    logic        to_q, to_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            ptr        <= 1'b0;
            eng_rd_req <= 1'b0;
            eng_wr_req <= 1'b0;
            eng_addr   <= '0;
            eng_wdata  <= '0;
            rdata_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            ptr        <= ptr_nxt;
            eng_rd_req <= rd_nxt;
            eng_wr_req <= wr_nxt;
            eng_addr   <= addr_nxt;
            eng_wdata  <= wdata_nxt;
            rdata_q    <= rdata_nxt;
`ifdef ARB_TIMEOUT_EN
            wd_cnt     <= wd_cnt_nxt;
            to_q       <= to_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        rd_nxt    = eng_rd_req;
        wr_nxt    = eng_wr_req;
        addr_nxt  = eng_addr;
        wdata_nxt = eng_wdata;
        rdata_nxt = rdata_q;
        sel_wr    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_cnt_nxt = wd_cnt;
        to_nxt     = to_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // Contention goes to the pointer; a lone request always wins.
                    owner_nxt = (bus.req0 & bus.req1) ? ptr : bus.req1;
                    sel_wr    = owner_nxt ? bus.wr1 : bus.wr0;
                    addr_nxt  = owner_nxt ? bus.addr1 : bus.addr0;
                    wdata_nxt = owner_nxt ? bus.wdata1 : bus.wdata0;
                    wr_nxt    = sel_wr;
                    rd_nxt    = ~sel_wr;
                    state_nxt = WAIT;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt_nxt = '0;
`endif
                end
            end
            WAIT: begin
                if (!eng_data_read_n)
                    rdata_nxt = eng_rdata;
`ifdef ARB_TIMEOUT_EN
                wd_cnt_nxt = wd_cnt + 6'd1;
`endif
                if (!eng_done_n) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    ptr_nxt   = ~owner;
                    state_nxt = ACK;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_cnt_nxt == 6'd63) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rdata_nxt = 8'hFF;
                    to_nxt    = 1'b1;
                    ptr_nxt   = ~owner;
                    state_nxt = ACK;
                end
`endif
            end
            ACK: begin
                state_nxt = IDLE;
`ifdef ARB_TIMEOUT_EN
                to_nxt    = 1'b0;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ack0  = (state == ACK) & ~owner;
    assign bus.ack1  = (state == ACK) & owner;
    assign bus.rdata = rdata_q;
    assign busy      = (state != IDLE);
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = to_q;
`endif

endmodule
